// File: rtl/clk1_div_ctrl.sv
// Programmable clock divider: turns clk1 into a glitch-free 50% duty clk_out with a
// rising-edge tick strobe. Ratio changes and stops only land on period boundaries.
module clk1_div_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    output logic             clk_out,
    output logic             tick,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] half_nx;
    logic [CNT_W-1:0] pend_half;
    logic [CNT_W-1:0] pend_half_nx;
    logic             pend_v;
    logic             pend_v_nx;
    logic             clk_out_nx;
    logic             tick_nx;

    logic             xfer;
    logic             wrap;
    logic             fall;
    logic             do_step;
    logic             boundary;
    logic [CNT_W-1:0] cfg_val;

    assign xfer    = cfg_valid & cfg_ready;
    assign cfg_val = (cfg_half == '0) ? ONE : cfg_half;
    assign wrap    = (cnt == (half - ONE));
    assign fall    = wrap & clk_out;
    assign busy    = (state != IDLE);

    // A stop seen during a low phase ends the run immediately; everything else in
    // RUN or DRAIN advances the divider by one clk1 cycle.
    assign do_step = (state == DRAIN) || ((state == RUN) && !(stop && !clk_out));

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        half_nx      = half;
        pend_half_nx = pend_half;
        pend_v_nx    = pend_v;
        clk_out_nx   = clk_out;
        tick_nx      = 1'b0;
        boundary     = 1'b0;

        if (do_step) begin
            if (wrap) begin
                cnt_nx     = '0;
                clk_out_nx = !clk_out;
                tick_nx    = !clk_out;
            end else begin
                cnt_nx = cnt + ONE;
            end
        end

        case (state)
            IDLE: begin
                cnt_nx     = '0;
                clk_out_nx = 1'b0;
                if (xfer) begin
                    half_nx = cfg_val;
                end
                if (start && !stop) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (stop && !clk_out) begin
                    state_nx   = IDLE;
                    cnt_nx     = '0;
                    clk_out_nx = 1'b0;
                    boundary   = 1'b1;
                end else begin
                    boundary = fall;
                    if (stop) begin
                        state_nx = fall ? IDLE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                boundary = fall;
                if (fall) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx   = IDLE;
                cnt_nx     = '0;
                clk_out_nx = 1'b0;
            end
        endcase

        if (boundary && pend_v) begin
            half_nx   = pend_half;
            pend_v_nx = 1'b0;
        end

        // A transfer can only happen with nothing pending, so it never collides with
        // the boundary load above; if the run is ending this edge, load it directly.
        if (xfer && (state != IDLE)) begin
            if (state_nx == IDLE) begin
                half_nx = cfg_val;
            end else begin
                pend_half_nx = cfg_val;
                pend_v_nx    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            half      <= ONE;
            pend_half <= ONE;
            pend_v    <= 1'b0;
            clk_out   <= 1'b0;
            tick      <= 1'b0;
            cfg_ready <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            half      <= half_nx;
            pend_half <= pend_half_nx;
            pend_v    <= pend_v_nx;
            clk_out   <= clk_out_nx;
            tick      <= tick_nx;
            cfg_ready <= !pend_v_nx;
        end
    end

endmodule
